// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: conversion sequencer for the 5-bit SARADC.
// It issues GO, follows the SAMPLE/VALID handshake, and accumulates 2^OSR results per burst.
// It then presents the averaged result and raw sum, and keeps sticky OVERRUN/TIMEOUT flags.
// Continuous mode inserts a programmable gap between conversions.
module adc_seq_ctrl #(
    parameter int RES_W   = 5,
    parameter int ACC_W   = 8,
    parameter int PER_W   = 8,
    parameter int TMO_CYC = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic             start_i,
    input  logic [1:0]       osr_i,
    input  logic [PER_W-1:0] period_i,
    input  logic             clr_flags_i,
    input  logic             ack_i,
    input  logic             adc_sample_i,
    input  logic             adc_valid_i,
    input  logic [RES_W-1:0] adc_result_i,
    output logic             adc_go_o,
    output logic [RES_W-1:0] data_o,
    output logic [ACC_W-1:0] sum_o,
    output logic             data_valid_o,
    output logic             pending_o,
    output logic             overrun_o,
    output logic             timeout_o,
    output logic             busy_o
);
    localparam int TMR_W = $clog2(TMO_CYC + 1);
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_CONV, S_WAIT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       osr_q, osr_d;
    logic [PER_W-1:0] gap_q, gap_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [RES_W-1:0] data_q, data_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic             adc_go_q, data_valid_q, busy_q;
    logic             ovr_set, tmo_set;
    logic [CNT_W-1:0] last_idx;
    logic             tmr_expired;

    // Index of the final sample of a burst, and handshake watchdog expiry.
    assign last_idx    = (CNT_W'(1) << osr_q) - CNT_W'(1);
    assign tmr_expired = (tmr_q == TMR_W'(TMO_CYC - 1));

    // Next-state, datapath and flag logic; every target defaults to hold.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        osr_d     = osr_q;
        gap_d     = gap_q;
        tmr_d     = tmr_q;
        data_d    = data_q;
        sum_d     = sum_q;
        pending_d = pending_q;
        ovr_set   = 1'b0;
        tmo_set   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en_i && (mode_i || start_i)) begin
                    state_d = S_ARM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    osr_d   = osr_i;
                    tmr_d   = '0;
                end
            end
            S_ARM: begin
                if (!en_i) begin
                    state_d = S_IDLE;
                end else if (adc_sample_i) begin
                    state_d = S_CONV;
                    tmr_d   = '0;
                end else if (tmr_expired) begin
                    state_d = S_IDLE;
                    tmo_set = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_CONV: begin
                if (!en_i) begin
                    state_d = S_IDLE;
                end else if (adc_valid_i) begin
                    acc_d = acc_q + ACC_W'(adc_result_i);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == last_idx) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        gap_d   = period_i;
                    end
                end else if (tmr_expired) begin
                    state_d = S_IDLE;
                    tmo_set = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_WAIT: begin
                // PERIOD of 0 or 1 both give a single gap cycle.
                if (!en_i) begin
                    state_d = S_IDLE;
                end else if (gap_q <= PER_W'(1)) begin
                    state_d = S_ARM;
                    tmr_d   = '0;
                end else begin
                    gap_d = gap_q - PER_W'(1);
                end
            end
            S_DONE: begin
                if (mode_i && en_i) begin
                    state_d = S_WAIT;
                    acc_d   = '0;
                    cnt_d   = '0;
                    gap_d   = period_i;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Result is published on entry to DONE so DATA and DATA_VALID line up.
        if (state_d == S_DONE) begin
            data_d = RES_W'(acc_d >> osr_q);
            sum_d  = acc_d;
        end

        // ACK sampled during DONE cannot clear the result DONE itself delivers.
        if (state_q == S_DONE) begin
            pending_d = 1'b1;
            ovr_set   = pending_q && !ack_i;
        end else if (ack_i) begin
            pending_d = 1'b0;
        end

        // Set events win over a simultaneous clear.
        overrun_d = ovr_set | (overrun_q & ~clr_flags_i);
        timeout_d = tmo_set | (timeout_q & ~clr_flags_i);
    end

    // State and output registers; outputs derive from the next state so they are glitch-free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            osr_q        <= '0;
            gap_q        <= '0;
            tmr_q        <= '0;
            data_q       <= '0;
            sum_q        <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            adc_go_q     <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            osr_q        <= osr_d;
            gap_q        <= gap_d;
            tmr_q        <= tmr_d;
            data_q       <= data_d;
            sum_q        <= sum_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
            adc_go_q     <= (state_d == S_ARM);
            data_valid_q <= (state_d == S_DONE);
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign adc_go_o     = adc_go_q;
    assign data_o       = data_q;
    assign sum_o        = sum_q;
    assign data_valid_o = data_valid_q;
    assign pending_o    = pending_q;
    assign overrun_o    = overrun_q;
    assign timeout_o    = timeout_q;
    assign busy_o       = busy_q;
endmodule

// File: tb/tb_adc_seq_ctrl.sv
// tb_adc_seq_ctrl: directed bench with a SARADC handshake model and a result scoreboard.
module tb_adc_seq_ctrl;
    localparam int RES_W = 5;
    localparam int ACC_W = 8;
    localparam int PER_W = 8;

    typedef struct {
        int data;
        int sum;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en_i, mode_i, start_i, clr_flags_i, ack_i;
    logic [1:0]       osr_i;
    logic [PER_W-1:0] period_i;
    logic             adc_sample_i, adc_valid_i;
    logic [RES_W-1:0] adc_result_i;
    logic             adc_go_o, data_valid_o, pending_o, overrun_o, timeout_o, busy_o;
    logic [RES_W-1:0] data_o;
    logic [ACC_W-1:0] sum_o;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   go_rises = 0, go_hi = 0, dv_cnt = 0, model_samples = 0;
    int   phase = 0, last_valid_cyc = -1, gap_checks = 0, gap_exp = 0;
    bit   gap_chk = 1'b0, go_prev = 1'b0, model_on = 1'b0;
    int   vals[$];
    exp_t exp_q[$];

    adc_seq_ctrl #(.RES_W(RES_W), .ACC_W(ACC_W), .PER_W(PER_W), .TMO_CYC(64)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en_i),
        .mode_i       (mode_i),
        .start_i      (start_i),
        .osr_i        (osr_i),
        .period_i     (period_i),
        .clr_flags_i  (clr_flags_i),
        .ack_i        (ack_i),
        .adc_sample_i (adc_sample_i),
        .adc_valid_i  (adc_valid_i),
        .adc_result_i (adc_result_i),
        .adc_go_o     (adc_go_o),
        .data_o       (data_o),
        .sum_o        (sum_o),
        .data_valid_o (data_valid_o),
        .pending_o    (pending_o),
        .overrun_o    (overrun_o),
        .timeout_o    (timeout_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, int obs, int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(int d, int s);
        exp_t e;
        e.data = d;
        e.sum  = s;
        exp_q.push_back(e);
    endtask

    // One cycle: observe outputs at the falling edge, then drive the SARADC model.
    task automatic tick();
        exp_t e;
        int   v;
        @(negedge clk);
        cyc++;
        start_i     = 1'b0;
        ack_i       = 1'b0;
        clr_flags_i = 1'b0;
        if (adc_go_o) go_hi++;
        if (adc_go_o && !go_prev) begin
            go_rises++;
            if (gap_chk && last_valid_cyc >= 0) begin
                gap_checks++;
                chk("wait_gap", cyc - last_valid_cyc - 1, gap_exp);
            end
        end
        go_prev = adc_go_o;
        if (data_valid_o) begin
            dv_cnt++;
            $display("[%0d] result data=%0d sum=%0d", cyc, data_o, sum_o);
            if (exp_q.size() == 0) begin
                chk("unexpected_dv", int'(data_valid_o), 0);
            end else begin
                e = exp_q.pop_front();
                chk("dv_data", int'(data_o), e.data);
                chk("dv_sum", int'(sum_o), e.sum);
            end
        end
        case (phase)
            0: if (model_on && adc_go_o) begin
                adc_sample_i = 1'b1;
                model_samples++;
                phase = 1;
            end
            1: begin
                v = (vals.size() > 0) ? vals.pop_front() : 0;
                adc_sample_i   = 1'b0;
                adc_valid_i    = 1'b1;
                adc_result_i   = v[RES_W-1:0];
                last_valid_cyc = cyc;
                phase = 2;
            end
            default: begin
                adc_valid_i = 1'b0;
                phase = 0;
            end
        endcase
    endtask

    task automatic wait_idle(string tag, int max);
        int n = 0;
        do begin
            tick();
            n++;
        end while (busy_o && n < max);
        chk({tag, "_idle"}, int'(busy_o), 0);
    endtask

    task automatic wait_dv(string tag, int target, int max);
        int n = 0;
        do begin
            tick();
            n++;
        end while (dv_cnt < target && n < max);
        chk(tag, dv_cnt, target);
    endtask

    initial begin
        int g0, d0, h0, s0, k0;
        rst_n = 1'b0; en_i = 1'b0; mode_i = 1'b0; start_i = 1'b0; clr_flags_i = 1'b0;
        ack_i = 1'b0; osr_i = 2'd0; period_i = '0;
        adc_sample_i = 1'b0; adc_valid_i = 1'b0; adc_result_i = '0;
        tick();
        tick();
        chk("rst_go", int'(adc_go_o), 0);
        chk("rst_data", int'(data_o), 0);
        chk("rst_sum", int'(sum_o), 0);
        chk("rst_dv", int'(data_valid_o), 0);
        chk("rst_pending", int'(pending_o), 0);
        chk("rst_overrun", int'(overrun_o), 0);
        chk("rst_timeout", int'(timeout_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        rst_n = 1'b1;
        tick();

        // Single shot, OSR=0, one result of 19.
        en_i = 1'b1; model_on = 1'b1;
        vals.push_back(19);
        push_exp(19, 19);
        g0 = go_rises; d0 = dv_cnt;
        start_i = 1'b1;
        wait_idle("single", 20);
        chk("single_go_count", go_rises - g0, 1);
        chk("single_dv_count", dv_cnt - d0, 1);
        chk("single_pending", int'(pending_o), 1);
        chk("single_data", int'(data_o), 19);
        chk("single_sb_empty", exp_q.size(), 0);

        // OSR=2, PERIOD=3: sum 47, average 11, three gap cycles each time.
        ack_i = 1'b1;
        tick();
        chk("ack_clears_pending", int'(pending_o), 0);
        osr_i = 2'd2; period_i = 8'd3;
        vals = {10, 11, 12, 14};
        push_exp(11, 47);
        gap_chk = 1'b1; gap_exp = 3; last_valid_cyc = -1; gap_checks = 0;
        start_i = 1'b1;
        wait_idle("osr2", 80);
        gap_chk = 1'b0;
        chk("osr2_gap_count", gap_checks, 3);
        chk("osr2_data", int'(data_o), 11);
        chk("osr2_sum", int'(sum_o), 47);
        chk("osr2_overrun", int'(overrun_o), 0);

        // Continuous, OSR=0, no ACK across two results, then ACK on a DONE.
        ack_i = 1'b1;
        tick();
        osr_i = 2'd0; period_i = 8'd0; mode_i = 1'b1;
        vals = {5, 6, 7};
        push_exp(5, 5); push_exp(6, 6); push_exp(7, 7);
        d0 = dv_cnt;
        wait_dv("cont_two", d0 + 2, 40);
        tick();
        chk("overrun_set", int'(overrun_o), 1);
        chk("cont_pending", int'(pending_o), 1);
        clr_flags_i = 1'b1;
        tick();
        chk("overrun_clr", int'(overrun_o), 0);
        wait_dv("cont_three", d0 + 3, 40);
        ack_i = 1'b1; mode_i = 1'b0;
        tick();
        chk("ack_at_done_pending", int'(pending_o), 1);
        chk("ack_at_done_overrun", int'(overrun_o), 0);
        wait_idle("cont_stop", 20);
        chk("cont_sb_empty", exp_q.size(), 0);

        // SARADC never samples: 64 cycles of GO, then TIMEOUT.
        model_on = 1'b0;
        h0 = go_hi; d0 = dv_cnt;
        start_i = 1'b1;
        wait_idle("tmo", 100);
        chk("tmo_go_cycles", go_hi - h0, 64);
        chk("tmo_flag", int'(timeout_o), 1);
        chk("tmo_go_low", int'(adc_go_o), 0);
        chk("tmo_no_dv", dv_cnt - d0, 0);
        clr_flags_i = 1'b1;
        tick();
        chk("tmo_clr", int'(timeout_o), 0);

        // EN dropped while converting the third sample of an OSR=2 burst.
        model_on = 1'b1; osr_i = 2'd2; ack_i = 1'b1;
        tick();
        vals = {1, 2, 3};
        s0 = model_samples; d0 = dv_cnt; k0 = 0;
        start_i = 1'b1;
        do begin
            tick();
            k0++;
        end while (model_samples < s0 + 3 && k0 < 60);
        chk("abort_third_sample", model_samples - s0, 3);
        tick();
        en_i = 1'b0;
        tick();
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_go", int'(adc_go_o), 0);
        chk("abort_data_kept", int'(data_o), 7);
        chk("abort_sum_kept", int'(sum_o), 7);
        chk("abort_no_dv", dv_cnt - d0, 0);
        tick();
        en_i = 1'b1;
        vals = {20, 21, 22, 23};
        push_exp(21, 86);
        start_i = 1'b1;
        wait_idle("fresh", 40);
        chk("fresh_sum", int'(sum_o), 86);
        chk("fresh_data", int'(data_o), 21);
        chk("fresh_sb_empty", exp_q.size(), 0);

        // Asynchronous reset between clock edges while GO is high.
        model_on = 1'b0;
        start_i = 1'b1;
        tick();
        tick();
        chk("prerst_go", int'(adc_go_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_go", int'(adc_go_o), 0);
        chk("arst_busy", int'(busy_o), 0);
        chk("arst_data", int'(data_o), 0);
        chk("arst_sum", int'(sum_o), 0);
        chk("arst_pending", int'(pending_o), 0);
        chk("arst_dv", int'(data_valid_o), 0);
        phase = 0; adc_sample_i = 1'b0; adc_valid_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
